// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes MIPS opcode/funct and registers the ALU operands behind a 2-entry skid buffer.
// It also resolves beq/bne from the ALU zero flag. Define ALU_ISSUE_STATS_EN to add the issued/stall counters.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALU_Control_sig,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  input  logic              zero_sig,
  output logic              illegal_op,
  output logic              branch_valid,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       issued_count,
  output logic [31:0]       stall_count
`endif
);

  localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(4'b0111);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] target;
    logic              br;
    logic              bne;
  } entry_t;

  entry_t            dec;
  logic              dec_legal;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] br_off;

  entry_t            out_q, out_d;
  entry_t            skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              illegal_q, illegal_d;
  logic              br_valid_q, br_valid_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0]       issued_q, issued_d;
  logic [31:0]       stall_q, stall_d;
`endif

  logic accept, push, pop, br_fire;

  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign br_off   = {imm_sext[DATA_W-3:0], 2'b00};

  // Instruction decode into an entry plus a legality flag
  always_comb begin
    dec        = '0;
    dec_legal  = 1'b0;
    dec.d1     = rs_data;
    dec.d2     = rt_data;
    dec.target = pc_plus4 + br_off;
    case (opcode)
      6'h00: begin
        dec_legal = 1'b1;
        case (funct)
          6'h20:   dec.ctrl = ALU_ADD;
          6'h22:   dec.ctrl = ALU_SUB;
          6'h24:   dec.ctrl = ALU_AND;
          6'h25:   dec.ctrl = ALU_OR;
          6'h2A:   dec.ctrl = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h23, 6'h2B, 6'h08: begin
        dec_legal = 1'b1;
        dec.ctrl  = ALU_ADD;
        dec.d2    = imm_sext;
      end
      6'h04, 6'h05: begin
        dec_legal = 1'b1;
        dec.ctrl  = ALU_SUB;
        dec.br    = 1'b1;
        dec.bne   = opcode[0];
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept  = in_valid && in_ready_q && !flush;
  assign push    = accept && dec_legal;
  assign pop     = out_valid_q && out_ready;
  assign br_fire = pop && out_q.br && !flush;

  // Next-state for the output/skid pair and the branch/illegal pulses
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    illegal_d    = accept && !dec_legal;
    br_valid_d   = br_fire;
    br_taken_d   = br_taken_q;
    br_target_d  = br_target_q;
`ifdef ALU_ISSUE_STATS_EN
    issued_d     = issued_q + 32'(pop);
    stall_d      = stall_q + 32'(out_valid_q && !out_ready);
`endif
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_d = dec;
      end
    end else if (!out_valid_q) begin
      out_valid_d = push;
      if (push) out_d = dec;
    end else if (push) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    if (br_fire) begin
      br_taken_d  = out_q.bne ? !zero_sig : zero_sig;
      br_target_d = out_q.target;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      illegal_q    <= 1'b0;
      br_valid_q   <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
`ifdef ALU_ISSUE_STATS_EN
      issued_q     <= '0;
      stall_q      <= '0;
`endif
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      illegal_q    <= illegal_d;
      br_valid_q   <= br_valid_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
`ifdef ALU_ISSUE_STATS_EN
      issued_q     <= issued_d;
      stall_q      <= stall_d;
`endif
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign ALU_Control_sig = out_q.ctrl;
  assign data_1          = out_q.d1;
  assign data_2          = out_q.d2;
  assign illegal_op      = illegal_q;
  assign branch_valid    = br_valid_q;
  assign branch_taken    = br_taken_q;
  assign branch_target   = br_target_q;
`ifdef ALU_ISSUE_STATS_EN
  assign issued_count    = issued_q;
  assign stall_count     = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a driver feeds directed and random instructions,
// and a monitor compares ALU operands, branch resolution and illegal pulses against a reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero_sig;
  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic [31:0] rs_data, rt_data, pc_plus4, data_1, data_2, branch_target;
  logic [3:0]  ALU_Control_sig;
  logic        illegal_op, branch_valid, branch_taken;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issued_count, stall_count;
`endif

  alu_issue_stage #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .imm(imm), .rs_data(rs_data), .rt_data(rt_data),
    .pc_plus4(pc_plus4), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Control_sig(ALU_Control_sig), .data_1(data_1), .data_2(data_2), .zero_sig(zero_sig),
    .illegal_op(illegal_op), .branch_valid(branch_valid), .branch_taken(branch_taken),
    .branch_target(branch_target)
`ifdef ALU_ISSUE_STATS_EN
    , .issued_count(issued_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU providing the zero flag
  logic [31:0] alu_res;
  always_comb begin
    case (ALU_Control_sig)
      4'b0010: alu_res = data_1 + data_2;
      4'b0110: alu_res = data_1 - data_2;
      4'b0000: alu_res = data_1 & data_2;
      4'b0001: alu_res = data_1 | data_2;
      4'b0111: alu_res = {31'd0, $signed(data_1) < $signed(data_2)};
      default: alu_res = 32'hFFFF_FFFF;
    endcase
  end
  assign zero_sig = (alu_res == 32'd0);

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] tgt;
    bit          br;
    bit          tk;
  } exp_t;

  exp_t exp_q[$];
  int   ill_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference decode straight from the instruction table
  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     output bit legal, output logic [3:0] ctrl,
                                     output bit use_imm, output bit br, output bit bne);
    legal = 1; ctrl = 4'b0000; use_imm = 0; br = 0; bne = 0;
    if (op == 6'h00) begin
      if      (fn == 6'h20) ctrl = 4'b0010;
      else if (fn == 6'h22) ctrl = 4'b0110;
      else if (fn == 6'h24) ctrl = 4'b0000;
      else if (fn == 6'h25) ctrl = 4'b0001;
      else if (fn == 6'h2A) ctrl = 4'b0111;
      else legal = 0;
    end else if (op == 6'h23 || op == 6'h2B || op == 6'h08) begin
      ctrl = 4'b0010; use_imm = 1;
    end else if (op == 6'h04 || op == 6'h05) begin
      ctrl = 4'b0110; br = 1; bne = (op == 6'h05);
    end else legal = 0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for one cycle and records the model's expectation if accepted
  task automatic drive_one(input bit v, input logic [5:0] op, input logic [5:0] fn,
                           input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] pc, output bit acc);
    bit legal, use_imm, br, bne;
    logic [3:0] ctrl;
    exp_t e;
    int off;
    in_valid = v; opcode = op; funct = fn; imm = im;
    rs_data = rs; rt_data = rt; pc_plus4 = pc;
    @(negedge clk);
    acc = v && in_ready && !flush && rst_n;
    if (acc) begin
      ref_decode(op, fn, legal, ctrl, use_imm, br, bne);
      if (legal) begin
        off = $signed(im);
        e.ctrl = ctrl;
        e.d1 = rs;
        e.d2 = use_imm ? 32'(off) : rt;
        e.br = br;
        e.tk = bne ? (rs != rt) : (rs == rt);
        e.tgt = pc + 32'(off * 4);
        exp_q.push_back(e);
      end else begin
        ill_q.push_back(cyc);
      end
    end
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic issue_retry(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                             input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc);
    bit acc;
    for (int t = 0; t < 50; t++) begin
      drive_one(1'b1, op, fn, im, rs, rt, pc, acc);
      if (acc) return;
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compares every output handshake and pulse against the scoreboard
  initial begin : monitor
    bit   pend_br = 0;
    bit   chk_reset = 0;
    bit   exp_ill;
    exp_t pb, e;
    pb = '{default: 0};
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (chk_reset) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ctrl", 32'(ALU_Control_sig), 32'd0);
        chk("rst_data_1", data_1, 32'd0);
        chk("rst_data_2", data_2, 32'd0);
        chk("rst_taken", 32'(branch_taken), 32'd0);
        chk("rst_target", branch_target, 32'd0);
        chk_reset = 0;
      end
      exp_ill = (ill_q.size() > 0) && (ill_q[0] == cyc - 1);
      if (exp_ill) void'(ill_q.pop_front());
      chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
      chk("branch_valid", 32'(branch_valid), 32'(pend_br));
      if (pend_br) begin
        chk("branch_taken", 32'(branch_taken), 32'(pb.tk));
        chk("branch_target", branch_target, pb.tgt);
      end
      pend_br = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("alu_ctrl", 32'(ALU_Control_sig), 32'(e.ctrl));
          chk("data_1", data_1, e.d1);
          chk("data_2", data_2, e.d2);
          if (e.br && rst_n && !flush) begin
            pend_br = 1;
            pb = e;
          end
        end
      end
      if (!rst_n || flush) exp_q.delete();
      if (!rst_n) begin
        chk_reset = 1;
        pend_br = 0;
      end
    end
  end

  initial begin : driver
    bit a1, a2, a3, acc;
    logic [5:0] ops[9];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    logic [31:0] rs, rt;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    opcode = 0; funct = 0; imm = 0; rs_data = 0; rt_data = 0; pc_plus4 = 0;
    repeat (2) next_cycle();
    rst_n = 1;
    next_cycle();

    // add, one-cycle latency
    drive_one(1'b1, 6'h00, 6'h20, 16'h0000, 32'd5, 32'd7, 32'h40, acc);
    chk("add_accept", 32'(acc), 32'd1);
    @(negedge clk);
    chk("add_latency", 32'(out_valid), 32'd1);
    next_cycle();
    issue_retry(6'h08, 6'h00, 16'hFFFC, 32'd16, 32'd3, 32'h44);
    issue_retry(6'h04, 6'h00, 16'h0003, 32'd9, 32'd9, 32'h100);
    issue_retry(6'h05, 6'h00, 16'h0003, 32'd9, 32'd9, 32'h100);
    repeat (3) next_cycle();

    // Back-pressure: two fit, third is refused
    out_ready = 0;
    drive_one(1'b1, 6'h00, 6'h22, 16'h0, 32'd20, 32'd4, 32'h0, a1);
    drive_one(1'b1, 6'h00, 6'h25, 16'h0, 32'hF0, 32'h0F, 32'h0, a2);
    drive_one(1'b1, 6'h00, 6'h2A, 16'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, a3);
    chk("bp_accept1", 32'(a1), 32'd1);
    chk("bp_accept2", 32'(a2), 32'd1);
    chk("bp_refuse3", 32'(a3), 32'd0);
    out_ready = 1;
    issue_retry(6'h00, 6'h2A, 16'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    repeat (4) next_cycle();

    // Flush with full skid while a branch pops
    out_ready = 0;
    issue_retry(6'h04, 6'h00, 16'h0010, 32'd3, 32'd3, 32'h200);
    issue_retry(6'h00, 6'h24, 16'h0, 32'hFF, 32'h0F, 32'h0);
    out_ready = 1; flush = 1;
    drive_one(1'b1, 6'h00, 6'h20, 16'h0, 32'd1, 32'd1, 32'h0, acc);
    chk("flush_ignores_in", 32'(acc), 32'd0);
    flush = 0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    next_cycle();

    // Illegal opcode
    issue_retry(6'h3F, 6'h00, 16'h0, 32'd1, 32'd2, 32'h0);
    @(negedge clk);
    chk("illegal_no_out", 32'(out_valid), 32'd0);
    next_cycle();
    repeat (2) next_cycle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 50) == 0);
      op = ops[$urandom_range(0, 8)];
      fn = fns[$urandom_range(0, 5)];
      rs = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      rt = ($urandom_range(0, 2) == 0) ? rs : 32'($urandom_range(0, 15));
      drive_one($urandom_range(0, 4) != 0, op, fn, 16'($urandom), rs, rt, $urandom, acc);
    end
    flush = 0;

    // Mid-stream reset
    out_ready = 0;
    issue_retry(6'h00, 6'h20, 16'h0, 32'd1, 32'd2, 32'h0);
    issue_retry(6'h05, 6'h00, 16'h8000, 32'd1, 32'd2, 32'h10);
    rst_n = 0;
    next_cycle();
    rst_n = 1;
    out_ready = 1;
    repeat (2) next_cycle();
    issue_retry(6'h00, 6'h22, 16'h0, 32'd9, 32'd2, 32'h0);

    // Drain and confirm nothing is left outstanding
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) next_cycle();
    repeat (2) next_cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("illegal_drained", 32'(ill_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU interface: decodes MIPS opcode/funct into the 4-bit ALU control code and selects both ALU operands.
- Presents the result to the ALU through a registered valid/ready stage with a 2-entry skid buffer.
- Consumes the ALU's combinational zero flag to resolve beq/bne one cycle after issue.
- Sits between register-file read (ID) and the ALU (EX).

Parameters:
- DATA_W, 32, operand/PC width.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept.
- opcode  input  6  instr[31:26].
- funct  input  6  instr[5:0].
- imm  input  16  instr[15:0].
- rs_data  input  DATA_W  register rs value.
- rt_data  input  DATA_W  register rt value.
- pc_plus4  input  DATA_W  PC+4 of the instruction.
- out_valid  output  1  ALU operands valid.
- out_ready  input  1  ALU/EX accepts.
- ALU_Control_sig  output  CTRL_W  ALU operation code.
- data_1  output  DATA_W  ALU operand A.
- data_2  output  DATA_W  ALU operand B.
- zero_sig  input  1  ALU zero flag (combinational on data_1/data_2).
- illegal_op  output  1  one-cycle pulse on a dropped undecodable instruction.
- branch_valid  output  1  one-cycle branch-resolution pulse.
- branch_taken  output  1  resolution result.
- branch_target  output  DATA_W  pc_plus4 + (sext(imm)<<2).

Behaviour:
- Reset (rst_n low at posedge):
  - out_valid=0, in_ready=1, skid empty, ALU_Control_sig=0, data_1=0, data_2=0.
  - illegal_op=0, branch_valid=0, branch_taken=0, branch_target=0.
  - Reset in mid-operation discards all entries; a pending branch resolution is lost.
- Decode (sext = 16-to-DATA_W sign extension):
  - R-type (opcode 0x00), data_2=rt_data: funct 0x20 add -> 0010; 0x22 sub -> 0110; 0x24 and -> 0000; 0x25 or -> 0001; 0x2A slt -> 0111.
  - lw 0x23, sw 0x2B, addi 0x08: 0010, data_2=sext(imm).
  - beq 0x04, bne 0x05: 0110, data_2=rt_data; tagged as branch.
  - data_1=rs_data always.
  - Anything else: accepted (handshake completes) but not enqueued; illegal_op=1 the following cycle.
- Buffering:
  - Main output register plus one skid register; in_ready = skid empty (registered).
  - Accept when in_valid && in_ready. Latency is 1 cycle from accept to out_valid when the stage is empty.
  - Output holds stable while out_valid && !out_ready.
  - Skid fills when an accept coincides with the output being held.
  - On pop, skid moves to the output register in the same edge.
  - Simultaneous pop and accept with skid empty: the new entry goes straight to the output; in_ready stays 1.
  - Order is strictly FIFO.
- Branch resolution:
  - At posedge where out_valid && out_ready and the entry is a branch, sample zero_sig.
  - Next cycle branch_valid=1, branch_taken = beq ? zero_sig : !zero_sig, branch_target computed from that entry's pc_plus4/imm.
  - branch_valid is otherwise 0; taken/target hold their last values.
- Flush:
  - At posedge, clears out_valid and the skid; in_valid that cycle is ignored; in_ready=1 next cycle.
  - Suppresses branch resolution and illegal_op from a handshake in the same cycle.
  - Does not cancel a branch_valid already asserted that cycle.
- Arithmetic: branch_target addition wraps modulo 2^DATA_W.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- Defined:
  - Adds outputs issued_count[31:0], stall_count[31:0], both reset to 0 and cleared by reset only (not flush).
  - issued_count increments on each out handshake.
  - stall_count increments each cycle with out_valid && !out_ready.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- add $rs=5, $rt=7 (opcode 0, funct 0x20), out_ready=1 -> next cycle out_valid=1, ALU_Control_sig=0010, data_1=5, data_2=7.
- addi imm=0xFFFC, rs=16 -> ALU_Control_sig=0010, data_2=0xFFFFFFFC.
- beq rs=rt=9, pc_plus4=0x100, imm=0x0003 -> cycle after handshake: branch_valid=1, branch_taken=1, branch_target=0x10C. bne with the same values -> branch_taken=0.
- Hold out_ready=0 and issue 3 back-to-back instructions -> first two accepted, in_ready=0 on the third. Release out_ready -> all three emerge in order.
- Skid full, then flush -> out_valid=0 and in_ready=1 next cycle; a branch popped in the flush cycle produces no branch_valid.
- opcode 0x3F -> no out_valid, illegal_op pulses once. Hold rst_n=0 for one edge mid-stream -> all outputs return to reset values.
